// File: rtl/key_hex_counter.sv
// Debounced up/down/clear push-button counter feeding a 4-digit seven-segment display value.
// Hex or BCD counting; value and val_stb update one clock after a debounced press pulse.
module key_hex_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit BCD             = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_up_n,
  input  logic        key_dn_n,
  input  logic        key_clr_n,
  output logic [15:0] value,
  output logic        val_stb,
  output logic [2:0]  key_level
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  localparam logic [23:0] LAST = 24'(DEBOUNCE_CYCLES - 1);

  logic [2:0]  raw_n;
  logic [2:0]  press;
  logic [15:0] value_nxt;
  logic        stb_nxt;

  assign raw_n = {key_clr_n, key_dn_n, key_up_n};

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic        sync1, sync2;
    logic        press_q, press_nxt;
    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        state   <= IDLE;
        cnt     <= '0;
        press_q <= 1'b0;
      end else begin
        sync1   <= raw_n[k];
        sync2   <= sync1;
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        press_q <= press_nxt;
      end
    end

    // The counter tracks consecutive samples at the new level; any opposite sample aborts the wait.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      case (state)
        IDLE: begin
          if (!sync2) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2) begin
            state_nxt = IDLE;
          end else if (cnt == LAST) begin
            state_nxt = HELD;
            press_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 24'd1;
          end
        end
        HELD: begin
          if (sync2) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (!sync2) begin
            state_nxt = HELD;
          end else if (cnt == LAST) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 24'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign press[k]     = press_q;
    assign key_level[k] = (state == HELD) || (state == RELEASE_WAIT);
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] >= 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // press = {clr, dn, up}; simultaneous up and dn cancel out.
  always_comb begin
    value_nxt = value;
    stb_nxt   = 1'b0;
    if (press[2]) begin
      value_nxt = 16'h0000;
      stb_nxt   = 1'b1;
    end else if (press[0] && !press[1]) begin
      value_nxt = BCD ? bcd_inc(value) : value + 16'd1;
      stb_nxt   = 1'b1;
    end else if (press[1] && !press[0]) begin
      value_nxt = BCD ? bcd_dec(value) : value - 16'd1;
      stb_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value   <= 16'h0000;
      val_stb <= 1'b0;
    end else begin
      value   <= value_nxt;
      val_stb <= stb_nxt;
    end
  end
endmodule

// File: tb/tb_key_hex_counter.sv
// Bench for key_hex_counter: hex and BCD instances share key inputs, each checked by its own scoreboard.
module tb_key_hex_counter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        key_up_n = 1'b1, key_dn_n = 1'b1, key_clr_n = 1'b1;
  logic [15:0] value_h, value_b;
  logic        stb_h, stb_b;
  logic [2:0]  lvl_h, lvl_b;

  int total = 0, bad = 0;
  int stb_cnt_h = 0, stb_cnt_b = 0;
  logic [15:0] q_h[$], q_b[$];
  logic [15:0] m_h = 16'h0000, m_b = 16'h0000;
  logic [15:0] exp_h, exp_b;

  key_hex_counter #(.DEBOUNCE_CYCLES(4), .BCD(1'b0)) dut_hex (
    .clock(clock), .reset(reset), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .key_clr_n(key_clr_n), .value(value_h), .val_stb(stb_h), .key_level(lvl_h));

  key_hex_counter #(.DEBOUNCE_CYCLES(4), .BCD(1'b1)) dut_bcd (
    .clock(clock), .reset(reset), .key_up_n(key_up_n), .key_dn_n(key_dn_n),
    .key_clr_n(key_clr_n), .value(value_b), .val_stb(stb_b), .key_level(lvl_b));

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (stb_h) begin
        stb_cnt_h++;
        total++;
        if (q_h.size() == 0) begin
          bad++;
          $display("FAIL hex_unexpected_stb: value=%h, no strobe expected", value_h);
        end else begin
          exp_h = q_h.pop_front();
          if (value_h !== exp_h) begin
            bad++;
            $display("FAIL hex_value: got %h want %h", value_h, exp_h);
          end
        end
      end
      if (stb_b) begin
        stb_cnt_b++;
        total++;
        if (q_b.size() == 0) begin
          bad++;
          $display("FAIL bcd_unexpected_stb: value=%h, no strobe expected", value_b);
        end else begin
          exp_b = q_b.pop_front();
          if (value_b !== exp_b) begin
            bad++;
            $display("FAIL bcd_value: got %h want %h", value_b, exp_b);
          end
        end
      end
    end
  end

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // op: 0 clear, 1 up, 2 down
  task automatic expect_op(input int op);
    case (op)
      0: begin m_h = 16'h0000; m_b = 16'h0000; end
      1: begin m_h = m_h + 16'd1; m_b = to_bcd((from_bcd(m_b) + 1) % 10000); end
      default: begin m_h = m_h - 16'd1; m_b = to_bcd((from_bcd(m_b) + 9999) % 10000); end
    endcase
    q_h.push_back(m_h);
    q_b.push_back(m_b);
  endtask

  // k = {clr, dn, up}, 1 = pressed
  task automatic set_keys(input logic [2:0] k);
    key_up_n  = ~k[0];
    key_dn_n  = ~k[1];
    key_clr_n = ~k[2];
  endtask

  task automatic press(input logic [2:0] k, input int op);
    expect_op(op);
    set_keys(k);
    cyc(10);
    set_keys(3'b000);
    cyc(12);
  endtask

  task automatic test_reset;
    cyc(3);
    total += 5;
    if (value_h !== 16'h0000) begin bad++; $display("FAIL reset_value_hex: got %h want 0000", value_h); end
    if (value_b !== 16'h0000) begin bad++; $display("FAIL reset_value_bcd: got %h want 0000", value_b); end
    if (stb_h !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", stb_h); end
    if (lvl_h !== 3'b000) begin bad++; $display("FAIL reset_level_hex: got %b want 000", lvl_h); end
    if (lvl_b !== 3'b000) begin bad++; $display("FAIL reset_level_bcd: got %b want 000", lvl_b); end
    reset = 1'b0;
    cyc(2);
  endtask

  task automatic test_up_clean;
    int s0;
    s0 = stb_cnt_h;
    expect_op(1);
    set_keys(3'b001);
    cyc(15);
    total++;
    if (lvl_h[0] !== 1'b1) begin bad++; $display("FAIL up_level_held: got %b want 1", lvl_h[0]); end
    cyc(5);
    set_keys(3'b000);
    cyc(3);
    total++;
    if (lvl_h[0] !== 1'b1) begin bad++; $display("FAIL up_level_release_wait: got %b want 1", lvl_h[0]); end
    cyc(9);
    total += 4;
    if (lvl_h[0] !== 1'b0) begin bad++; $display("FAIL up_level_released: got %b want 0", lvl_h[0]); end
    if (stb_cnt_h - s0 !== 1) begin bad++; $display("FAIL up_stb_count: got %0d want 1", stb_cnt_h - s0); end
    if (value_h !== 16'h0001) begin bad++; $display("FAIL up_value: got %h want 0001", value_h); end
    if (q_h.size() !== 0) begin bad++; $display("FAIL up_missing_stb: %0d pending want 0", q_h.size()); end
  endtask

  task automatic test_dn_bounce;
    int s0;
    press(3'b100, 0);
    s0 = stb_cnt_h;
    for (int r = 0; r < 4; r++) begin
      set_keys(3'b010);
      cyc(2);
      set_keys(3'b000);
      cyc(1);
    end
    total += 2;
    if (stb_cnt_h !== s0) begin bad++; $display("FAIL dn_bounce_stb: got %0d strobes want 0", stb_cnt_h - s0); end
    if (lvl_h[1] !== 1'b0) begin bad++; $display("FAIL dn_bounce_level: got %b want 0", lvl_h[1]); end
    press(3'b010, 2);
    total += 4;
    if (stb_cnt_h - s0 !== 1) begin bad++; $display("FAIL dn_stb_count: got %0d want 1", stb_cnt_h - s0); end
    if (value_h !== 16'hFFFF) begin bad++; $display("FAIL dn_wrap_hex: got %h want FFFF", value_h); end
    if (value_b !== 16'h9999) begin bad++; $display("FAIL dn_wrap_bcd: got %h want 9999", value_b); end
    if (q_b.size() !== 0) begin bad++; $display("FAIL dn_missing_stb: %0d pending want 0", q_b.size()); end
    press(3'b001, 1);
    total += 2;
    if (value_h !== 16'h0000) begin bad++; $display("FAIL up_wrap_hex: got %h want 0000", value_h); end
    if (value_b !== 16'h0000) begin bad++; $display("FAIL up_wrap_bcd: got %h want 0000", value_b); end
  endtask

  task automatic test_bcd_carry;
    press(3'b100, 0);
    for (int i = 0; i < 10; i++) press(3'b001, 1);
    total += 2;
    if (value_b !== 16'h0010) begin bad++; $display("FAIL bcd_carry: got %h want 0010", value_b); end
    if (value_h !== 16'h000A) begin bad++; $display("FAIL hex_count10: got %h want 000A", value_h); end
    press(3'b010, 2);
    total += 2;
    if (value_b !== 16'h0009) begin bad++; $display("FAIL bcd_borrow: got %h want 0009", value_b); end
    if (value_h !== 16'h0009) begin bad++; $display("FAIL hex_dec: got %h want 0009", value_h); end
  endtask

  task automatic test_same_clock;
    int s0;
    press(3'b100, 0);
    for (int i = 0; i < 5; i++) press(3'b001, 1);
    total++;
    if (value_h !== 16'h0005) begin bad++; $display("FAIL preset5: got %h want 0005", value_h); end
    s0 = stb_cnt_h;
    press(3'b101, 0);
    total += 2;
    if (stb_cnt_h - s0 !== 1) begin bad++; $display("FAIL clr_up_stb: got %0d want 1", stb_cnt_h - s0); end
    if (value_h !== 16'h0000) begin bad++; $display("FAIL clr_up_value: got %h want 0000", value_h); end
    press(3'b001, 1);
    s0 = stb_cnt_h;
    set_keys(3'b011);
    cyc(10);
    set_keys(3'b000);
    cyc(12);
    total += 3;
    if (stb_cnt_h !== s0) begin bad++; $display("FAIL up_dn_cancel_stb: got %0d want 0", stb_cnt_h - s0); end
    if (value_h !== 16'h0001) begin bad++; $display("FAIL up_dn_cancel_hex: got %h want 0001", value_h); end
    if (value_b !== 16'h0001) begin bad++; $display("FAIL up_dn_cancel_bcd: got %h want 0001", value_b); end
  endtask

  task automatic test_reset_mid_press;
    int n;
    set_keys(3'b001);
    cyc(5);
    reset = 1'b1;
    q_h.delete();
    q_b.delete();
    m_h = 16'h0000;
    m_b = 16'h0000;
    cyc(1);
    total += 3;
    if (value_h !== 16'h0000) begin bad++; $display("FAIL midreset_value_hex: got %h want 0000", value_h); end
    if (value_b !== 16'h0000) begin bad++; $display("FAIL midreset_value_bcd: got %h want 0000", value_b); end
    if (stb_h !== 1'b0) begin bad++; $display("FAIL midreset_stb: got %b want 0", stb_h); end
    cyc(2);
    reset = 1'b0;
    expect_op(1);
    n = 0;
    while (n < 40) begin
      cyc(1);
      n++;
      if (stb_h === 1'b1) break;
    end
    total += 2;
    if (n >= 40) begin bad++; $display("FAIL midreset_timeout: no strobe within %0d clocks", n); end
    if (n < 6) begin bad++; $display("FAIL midreset_latency: strobe after %0d clocks want >= 6", n); end
    cyc(4);
    set_keys(3'b000);
    cyc(12);
    total += 2;
    if (value_h !== 16'h0001) begin bad++; $display("FAIL midreset_value: got %h want 0001", value_h); end
    if (q_h.size() !== 0) begin bad++; $display("FAIL midreset_pending: %0d pending want 0", q_h.size()); end
  endtask

  initial begin
    test_reset();
    test_up_clean();
    test_dn_bounce();
    test_bcd_carry();
    test_same_clock();
    test_reset_mid_press();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_hex_counter.md
KEY_HEX_COUNTER -- requirements
Module: key_hex_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clocks needed to accept a key level change (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter BCD, default 0: 0 selects hex counting, 1 selects 4-digit decimal (BCD) counting.
REQ-003 SHALL have port clock  input  1: the single system clock; all state is on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port key_up_n  input  1: raw board push-button, active-low, asynchronous to clock, may bounce.
REQ-006 SHALL have port key_dn_n  input  1: raw push-button, active-low; decrement request.
REQ-007 SHALL have port key_clr_n  input  1: raw push-button, active-low; clear request.
REQ-008 SHALL have port value  output  16: four nibbles, [3:0] least significant digit, consumed by the seven-segment display stage.
REQ-009 SHALL have port val_stb  output  1: one-clock pulse in the cycle value takes a new result.
REQ-010 SHALL have port key_level  output  3: debounced pressed levels {clr,dn,up}, 1 = pressed.

Function
REQ-011 Each raw key SHALL pass through a two-flop synchronizer before any other logic; outputs of the synchronizers are "sync keys".
REQ-012 Each key SHALL have its own debounce FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT and its own 24-bit stability counter.
REQ-013 IDLE -> PRESS_WAIT when the sync key is low; counter cleared.
REQ-014 PRESS_WAIT: counter increments each clock the sync key is low; sync key high returns to IDLE, no pulse.
REQ-015 PRESS_WAIT -> HELD after the sync key is low for DEBOUNCE_CYCLES consecutive clocks; a one-clock press pulse is issued on that transition.
REQ-016 HELD -> RELEASE_WAIT when the sync key is high; RELEASE_WAIT returns to HELD on any low sample, else -> IDLE after DEBOUNCE_CYCLES consecutive high clocks.
REQ-017 key_level bit SHALL be 1 in HELD and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-018 A held key SHALL produce exactly one press pulse; no auto-repeat.
REQ-019 value SHALL update on the clock edge following a press pulse; val_stb asserts for that one clock and only when a pulse was acted on.
REQ-020 Priority in the same clock: clr pulse wins (value <= 0, val_stb = 1); else up and dn together cancel (value unchanged, val_stb = 0); else up increments or dn decrements.
REQ-021 BCD=0: value arithmetic is modulo 2^16; 16'hFFFF + 1 = 16'h0000, 16'h0000 - 1 = 16'hFFFF.
REQ-022 BCD=1: each nibble stays in 0..9 with ripple carry/borrow; 16'h9999 + 1 = 16'h0000, 16'h0000 - 1 = 16'h9999, 16'h0109 + 1 = 16'h0110, 16'h0100 - 1 = 16'h0099.
REQ-023 Clear while value is already 0 SHALL still assert val_stb.

Reset
REQ-024 reset high SHALL immediately force value = 16'h0000, val_stb = 0, key_level = 3'b000, all FSMs to IDLE, counters and synchronizers to the released (high) level.
REQ-025 Reset asserted mid-press SHALL discard the press; after release of reset a still-held key SHALL restart at PRESS_WAIT and take the full DEBOUNCE_CYCLES before pulsing.

Verification (DEBOUNCE_CYCLES = 4 for all benches)
REQ-026 Clean press of key_up_n held for 20 clocks, BCD=0, from reset -> exactly one val_stb; value = 16'h0001; key_level[0] = 1 until released and debounced.
REQ-027 key_dn_n bouncing low 2 clocks / high 1 clock for 12 clocks, then stable low -> no pulse during bounce; one val_stb; value 16'h0000 -> 16'hFFFF.
REQ-028 BCD=1, value preset by 9999 up-presses, or by one down-press from 0 -> value 16'h9999; one more up-press -> 16'h0000.
REQ-029 key_up_n and key_clr_n pressed on the same clock with value 16'h0005 -> value 16'h0000, single val_stb; up and dn aligned -> value unchanged, no val_stb.
REQ-030 Reset pulsed while key_up_n is in PRESS_WAIT with the key kept low -> value stays 16'h0000 during reset; first val_stb no earlier than 2 + 4 clocks after reset deasserts; value = 16'h0001.
